// File: rtl/vga_sync_gen_if.sv
// Timing bundle between the VGA sync generator and its consumers.
interface vga_sync_gen_if;
    logic       ce;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    // Generator side: takes the pixel enable, drives the raster position and syncs.
    modport master (
        input  ce,
        output hpos,
        output vpos,
        output hsync,
        output vsync,
        output display_on,
        output line_start,
        output frame_start,
        output frame_count
    );

    // Consumer side: supplies the pixel enable, observes the raster.
    modport slave (
        output ce,
        input  hpos,
        input  vpos,
        input  hsync,
        input  vsync,
        input  display_on,
        input  line_start,
        input  frame_start,
        input  frame_count
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, active-low syncs,
// visible-area flag, line/frame start strobes and a completed-frame counter.
module vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vif
);

    localparam int unsigned CW       = 10;
    localparam int unsigned FW       = 8;
    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_LO    = CW'(HS_START);
    localparam logic [CW-1:0] HS_HI    = CW'(HS_END);
    localparam logic [CW-1:0] VS_LO    = CW'(VS_START);
    localparam logic [CW-1:0] VS_HI    = CW'(VS_END);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [FW-1:0] fc_cnt;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic [FW-1:0] fc_nxt;

    logic hsync_q;
    logic vsync_q;
    logic disp_q;
    logic lstart_q;
    logic fstart_q;
    logic hsync_nxt;
    logic vsync_nxt;
    logic disp_nxt;
    logic lstart_nxt;
    logic fstart_nxt;

    // Next raster position; >= compares pull any stray value back to the origin.
    always_comb begin
        h_nxt  = h_cnt;
        v_nxt  = v_cnt;
        fc_nxt = fc_cnt;
        if (vif.ce) begin
            if (h_cnt >= H_LAST) begin
                h_nxt = '0;
                if (v_cnt >= V_LAST) begin
                    v_nxt  = '0;
                    fc_nxt = fc_cnt + FW'(1);
                end else begin
                    v_nxt = v_cnt + CW'(1);
                end
            end else begin
                h_nxt = h_cnt + CW'(1);
            end
        end
    end

    // Decode outputs from the next position so they register alongside the counters.
    always_comb begin
        hsync_nxt  = 1'b1;
        vsync_nxt  = 1'b1;
        disp_nxt   = 1'b0;
        lstart_nxt = 1'b0;
        fstart_nxt = 1'b0;
        if ((h_nxt >= HS_LO) && (h_nxt < HS_HI)) begin
            hsync_nxt = 1'b0;
        end
        if ((v_nxt >= VS_LO) && (v_nxt < VS_HI)) begin
            vsync_nxt = 1'b0;
        end
        if ((h_nxt < H_VIS) && (v_nxt < V_VIS)) begin
            disp_nxt = 1'b1;
        end
        if (h_nxt == '0) begin
            lstart_nxt = 1'b1;
            if (v_nxt == '0) begin
                fstart_nxt = 1'b1;
            end
        end
    end

    // Counter and output registers; reset parks the raster at the origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            fc_cnt   <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            disp_q   <= 1'b1;
            lstart_q <= 1'b1;
            fstart_q <= 1'b1;
        end else begin
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            fc_cnt   <= fc_nxt;
            hsync_q  <= hsync_nxt;
            vsync_q  <= vsync_nxt;
            disp_q   <= disp_nxt;
            lstart_q <= lstart_nxt;
            fstart_q <= fstart_nxt;
        end
    end

    assign vif.hpos        = h_cnt;
    assign vif.vpos        = v_cnt;
    assign vif.frame_count = fc_cnt;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.display_on  = disp_q;
    assign vif.line_start  = lstart_q;
    assign vif.frame_start = fstart_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance for horizontal behaviour
// and a shrunken-timing instance for vertical, frame-wrap and reset behaviour.
module tb_vga_sync_gen;

    // Shrunken raster: 16 clocks per line, 10 lines per frame.
    localparam int unsigned S_HD = 10;
    localparam int unsigned S_HF = 2;
    localparam int unsigned S_HS = 3;
    localparam int unsigned S_HB = 1;
    localparam int unsigned S_VD = 6;
    localparam int unsigned S_VF = 1;
    localparam int unsigned S_VS = 2;
    localparam int unsigned S_VB = 1;
    localparam int unsigned S_FRAME = (S_HD + S_HF + S_HS + S_HB) * (S_VD + S_VF + S_VS + S_VB);

    typedef struct packed {
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       hsync;
        logic       vsync;
        logic       disp;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        string       name;
        int unsigned edges;
        logic        ce;
        obs_t        exp;
    } vec_t;

    logic clk;
    logic rst_n_d;
    logic rst_n_s;
    int   total;
    int   bad;
    longint unsigned n_d;
    longint unsigned n_s;

    vga_sync_gen_if vif_d ();
    vga_sync_gen_if vif_s ();

    vga_sync_gen u_dut_d (
        .clk   (clk),
        .rst_n (rst_n_d),
        .vif   (vif_d)
    );

    vga_sync_gen #(
        .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
    ) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n_s),
        .vif   (vif_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input int h, input int v, input bit hs, input bit vs,
                                input bit de, input bit ls, input bit fs, input int fc);
        obs_t o;
        o.hpos = 10'(h);
        o.vpos = 10'(v);
        o.hsync = hs;
        o.vsync = vs;
        o.disp = de;
        o.ls = ls;
        o.fs = fs;
        o.fc = 8'(fc);
        return o;
    endfunction

    // Raster state after n enabled edges since reset, from plain division.
    function automatic obs_t model(input longint unsigned n,
                                   input longint unsigned hd, input longint unsigned hf,
                                   input longint unsigned hs, input longint unsigned hb,
                                   input longint unsigned vd, input longint unsigned vf,
                                   input longint unsigned vs, input longint unsigned vb);
        longint unsigned ht, vt, h, line, v, f;
        obs_t o;
        ht   = hd + hf + hs + hb;
        vt   = vd + vf + vs + vb;
        h    = n % ht;
        line = n / ht;
        v    = line % vt;
        f    = (line / vt) % 256;
        o.hpos  = 10'(h);
        o.vpos  = 10'(v);
        o.hsync = !((h >= hd + hf) && (h < hd + hf + hs));
        o.vsync = !((v >= vd + vf) && (v < vd + vf + vs));
        o.disp  = (h < hd) && (v < vd);
        o.ls    = (h == 0);
        o.fs    = (h == 0) && (v == 0);
        o.fc    = 8'(f);
        return o;
    endfunction

    function automatic obs_t model_d(input longint unsigned n);
        return model(n, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t model_s(input longint unsigned n);
        return model(n, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB);
    endfunction

    function automatic obs_t sample_d();
        return mk(int'(vif_d.hpos), int'(vif_d.vpos), vif_d.hsync, vif_d.vsync,
                  vif_d.display_on, vif_d.line_start, vif_d.frame_start, int'(vif_d.frame_count));
    endfunction

    function automatic obs_t sample_s();
        return mk(int'(vif_s.hpos), int'(vif_s.vpos), vif_s.hsync, vif_s.vsync,
                  vif_s.display_on, vif_s.line_start, vif_s.frame_start, int'(vif_s.frame_count));
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d, want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                     name, act.hpos, act.vpos, act.hsync, act.vsync, act.disp, act.ls, act.fs, act.fc,
                     exp.hpos, exp.vpos, exp.hsync, exp.vsync, exp.disp, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0/1: constant ce, mode 2: random ce (about 75% enabled).
    task automatic run_d(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            vif_d.ce = (mode == 2) ? ($urandom_range(0, 3) != 0) : (mode == 1);
            tick();
            if (vif_d.ce) n_d++;
            check("d_track", sample_d(), model_d(n_d));
        end
    endtask

    task automatic run_s(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            vif_s.ce = (mode == 2) ? ($urandom_range(0, 3) != 0) : (mode == 1);
            tick();
            if (vif_s.ce) n_s++;
            check("s_track", sample_s(), model_s(n_s));
        end
    endtask

    task automatic reset_s();
        vif_s.ce = 1'b0;
        rst_n_s  = 1'b0;
        tick();
        rst_n_s  = 1'b1;
        n_s      = 0;
    endtask

    vec_t vecs[$];

    initial begin
        int cnt_a;
        int cnt_b;
        total   = 0;
        bad     = 0;
        n_d     = 0;
        n_s     = 0;
        rst_n_d = 1'b0;
        rst_n_s = 1'b0;
        vif_d.ce = 1'b1;
        vif_s.ce = 1'b1;
        repeat (3) tick();
        check("d_in_reset", sample_d(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        check("s_in_reset", sample_s(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        rst_n_d = 1'b1;
        rst_n_s = 1'b1;
        vif_s.ce = 1'b0;

        // Horizontal walk on default timing, edge counts cumulative from release.
        vecs.push_back('{"rst_release", 0,  1'b1, mk(0,   0, 1, 1, 1, 1, 1, 0)});
        vecs.push_back('{"first_edge",  1,  1'b1, mk(1,   0, 1, 1, 1, 0, 0, 0)});
        vecs.push_back('{"h639",        638, 1'b1, mk(639, 0, 1, 1, 1, 0, 0, 0)});
        vecs.push_back('{"h640",        1,  1'b1, mk(640, 0, 1, 1, 0, 0, 0, 0)});
        vecs.push_back('{"h655",        15, 1'b1, mk(655, 0, 1, 1, 0, 0, 0, 0)});
        vecs.push_back('{"ce_hold",     50, 1'b0, mk(655, 0, 1, 1, 0, 0, 0, 0)});
        vecs.push_back('{"h656",        1,  1'b1, mk(656, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"h751",        95, 1'b1, mk(751, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"h752",        1,  1'b1, mk(752, 0, 1, 1, 0, 0, 0, 0)});
        vecs.push_back('{"h799",        47, 1'b1, mk(799, 0, 1, 1, 0, 0, 0, 0)});
        vecs.push_back('{"line1",       1,  1'b1, mk(0,   1, 1, 1, 1, 1, 0, 0)});
        foreach (vecs[k]) begin
            vif_d.ce = vecs[k].ce;
            repeat (vecs[k].edges) tick();
            if (vecs[k].ce) n_d += vecs[k].edges;
            check(vecs[k].name, sample_d(), vecs[k].exp);
        end

        // Random enable against the model, then count hsync-low clocks over a full line.
        run_d(1500, 2);
        while ((n_d % 800) != 0) run_d(1, 1);
        cnt_a = 0;
        for (int i = 0; i < 800; i++) begin
            run_d(1, 1);
            if (vif_d.hsync == 1'b0) cnt_a++;
        end
        check_int("hsync_low_per_line", cnt_a, 96);

        // Mid-line async reset on the default instance.
        run_d(300, 1);
        rst_n_d = 1'b0;
        #1;
        check("d_async_reset", sample_d(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        tick();
        rst_n_d = 1'b1;
        n_d = 0;
        run_d(20, 2);

        // Shrunken timing: random enable, then vsync / blanking counts over one frame.
        reset_s();
        check("s_after_reset", sample_s(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        run_s(3000, 2);
        while ((n_s % S_FRAME) != 0) run_s(1, 1);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < int'(S_FRAME); i++) begin
            run_s(1, 1);
            if (vif_s.vsync == 1'b0) cnt_a++;
            if (vif_s.vpos >= 10'(S_VD) && vif_s.display_on == 1'b0) cnt_b++;
        end
        check_int("vsync_low_per_frame", cnt_a, 32);
        check_int("vblank_dark_cycles", cnt_b, 64);

        // Frame wrap and 256-frame rollover, including a frozen frame_start.
        reset_s();
        run_s(int'(S_FRAME) - 1, 1);
        check("s_last_pixel", sample_s(), mk(15, 9, 1, 1, 0, 0, 0, 0));
        run_s(1, 1);
        check("s_frame_wrap", sample_s(), mk(0, 0, 1, 1, 1, 1, 1, 1));
        run_s(5, 0);
        check("s_fs_frozen", sample_s(), mk(0, 0, 1, 1, 1, 1, 1, 1));
        run_s(255 * int'(S_FRAME), 1);
        check("s_fc_rollover", sample_s(), mk(0, 0, 1, 1, 1, 1, 1, 0));

        // Mid-frame reset at (5,4) with three frames completed.
        reset_s();
        run_s(3 * int'(S_FRAME) + 4 * 16 + 5, 1);
        check("s_pre_reset", sample_s(), mk(5, 4, 1, 1, 1, 0, 0, 3));
        rst_n_s = 1'b0;
        #1;
        check("s_async_reset", sample_s(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        tick();
        check("s_reset_held", sample_s(), mk(0, 0, 1, 1, 1, 1, 1, 0));
        rst_n_s = 1'b1;
        n_s = 0;
        vif_s.ce = 1'b1;
        tick();
        check("s_first_edge", sample_s(), mk(1, 0, 1, 1, 1, 0, 0, 0));
        n_s = 1;
        run_s(40, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
